pps_freq_meter: RTL

PPS_FREQ_METER -- requirements
Module: pps_freq_meter

---
 rtl/pps_freq_meter_pkg.sv | 15 +
 rtl/pps_freq_meter_edge_sync.sv | 28 ++
 rtl/pps_freq_meter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/pps_freq_meter_pkg.sv
// Shared definitions for the GPS 1PPS period meter: FSM state encoding and
// default sizing for a nominal 1 MHz-per-second system clock.
package pps_freq_meter_pkg;

    localparam int DEF_CNT_W      = 24;
    localparam int DEF_MIN_PERIOD = 900_000;
    localparam int DEF_TIMEOUT    = 1_100_000;
    localparam int NOMINAL_COUNT  = 1_000_000;

    typedef enum logic {
        WAIT_FIRST = 1'b0,
        COUNT      = 1'b1
    } state_t;

endpackage

// File: rtl/pps_freq_meter_edge_sync.sv
// Brings the asynchronous 1PPS into CLK_SYS with a 2-flop synchronizer and
// produces a single-cycle rising-edge strobe from a history flop.
module pps_edge_sync (
    input  logic CLK_SYS,
    input  logic CLK_RST,
    input  logic Gps_Pps,
    output logic pps_edge
);

    logic sync_p0;
    logic sync_p1;
    logic hist_p2;

    always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
        if (!CLK_RST) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            hist_p2 <= 1'b0;
        end else begin
            sync_p0 <= Gps_Pps;
            sync_p1 <= sync_p0;
            hist_p2 <= sync_p1;
        end
    end

    assign pps_edge = sync_p1 & ~hist_p2;

endmodule

// File: rtl/pps_freq_meter.sv
// GPS 1PPS period meter: counts CLK_SYS cycles between accepted PPS edges and
// rejects edges arriving sooner than MIN_PERIOD. Define PPS_TIMEOUT_EN to add
// loss-of-PPS detection after TIMEOUT cycles without an accepted edge.
module pps_freq_meter
    import pps_freq_meter_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int MIN_PERIOD = DEF_MIN_PERIOD,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic             CLK_SYS,
    input  logic             CLK_RST,
    input  logic             Gps_Pps,
    output logic [CNT_W-1:0] Measure_Phase,
    output logic             Measure_Done,
    output logic             Pps_Valid,
    output logic             Pps_Lost
);

    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PERIOD);

    logic             pps_edge;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             start;
    logic             accept;
    logic             done_vld_p0;

    // Counter saturates at all-ones so an overlong period reads as full scale
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    pps_edge_sync u_edge_sync (
        .CLK_SYS  (CLK_SYS),
        .CLK_RST  (CLK_RST),
        .Gps_Pps  (Gps_Pps),
        .pps_edge (pps_edge)
    );

`ifdef PPS_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    logic timeout;
    logic lost_q;
`endif

    always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
        if (!CLK_RST) begin
            state_q <= WAIT_FIRST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        accept  = 1'b0;
`ifdef PPS_TIMEOUT_EN
        timeout = 1'b0;
`endif
        case (state_q)
            WAIT_FIRST: begin
                if (pps_edge) begin
                    start   = 1'b1;
                    state_d = COUNT;
                end
            end
            COUNT: begin
                // A qualifying edge beats a coincident timeout
                if (pps_edge && (cnt_q >= MIN_CNT)) begin
                    accept = 1'b1;
                end
`ifdef PPS_TIMEOUT_EN
                else if (cnt_q >= TIMEOUT_CNT) begin
                    timeout = 1'b1;
                    state_d = WAIT_FIRST;
                end
`endif
            end
            default: state_d = WAIT_FIRST;
        endcase
    end

    always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
        if (!CLK_RST) begin
            cnt_q <= '0;
        end else if (start || accept) begin
            cnt_q <= CNT_W'(1);
`ifdef PPS_TIMEOUT_EN
        end else if (timeout) begin
            cnt_q <= '0;
`endif
        end else if (state_q == COUNT) begin
            cnt_q <= sat_inc(cnt_q);
        end
    end

    // Stage p0: latch the period; Measure_Done follows one cycle later
    always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
        if (!CLK_RST) begin
            Measure_Phase <= '0;
            done_vld_p0   <= 1'b0;
            Measure_Done  <= 1'b0;
            Pps_Valid     <= 1'b0;
        end else begin
            done_vld_p0  <= accept;
            Measure_Done <= done_vld_p0;
            if (accept) begin
                Measure_Phase <= cnt_q;
                Pps_Valid     <= 1'b1;
            end
`ifdef PPS_TIMEOUT_EN
            else if (timeout) begin
                Pps_Valid <= 1'b0;
            end
`endif
        end
    end

`ifdef PPS_TIMEOUT_EN
    always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
        if (!CLK_RST) begin
            lost_q <= 1'b0;
        end else if (accept) begin
            lost_q <= 1'b0;
        end else if (timeout) begin
            lost_q <= 1'b1;
        end
    end

    assign Pps_Lost = lost_q;
`else
    assign Pps_Lost = 1'b0;
`endif

endmodule
